nn_param_sequencer: RTL and testbench

- Byte-stream front end for the 3-layer spiking network core (32 inputs, 4/4/4 neurons).
- Decodes host command bytes and serializes parameters as 2-bit dibits into the five parameter shift chains, with the matching load-enable strobes.
- Loads the 32-bit input vector bytewise and runs N inference timesteps by pulsing the core clock-enable.
- Accumulates per-output-neuron spike counts and reports them when the run finishes.

---
 rtl/nn_param_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_nn_param_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_param_sequencer.sv
// ---------------------------------------------------------------------------
// nn_param_sequencer
//
// Byte-stream front end for the 3-layer spiking network core. Host command
// bytes are decoded in the HDR state; the low three header bits select:
//   0..4 : parameter load (W, BETA, TETA, BNF, BNA). Payload bytes are
//          serialized LSB-dibit first onto nn_parameters with the matching
//          chain strobe, truncated to ceil(BITS/2) dibits.
//   5    : input vector load, IN_BYTES bytes, one fifo_inputs_ce per byte.
//   6    : run. The next byte is the step count N; nn_ce pulses N cycles and
//          spikes are accumulated into saturating per-neuron counters.
//   7    : illegal, err pulses and the byte is dropped.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   host byte stream (transfer = valid & ready)
//   nn_parameters               dibit to parameter chains (0 when idle)
//   fifo_*_ce                   parameter chain shift strobes (one-hot)
//   inputs/fifo_inputs_ce       input chain byte and strobe
//   nn_ce                       core timestep enable
//   spikes                      core spike outputs
//   spike_count                 counters, neuron i at [i*CW +: CW]
//   result_valid                counters hold a finished run
//   done/err                    one-cycle completion / illegal header pulses
//   busy                        high whenever not waiting for a header
// ---------------------------------------------------------------------------
module nn_param_sequencer #(
    parameter int W_BITS    = 160,
    parameter int BETA_BITS = 9,
    parameter int TETA_BITS = 15,
    parameter int BNF_BITS  = 48,
    parameter int BNA_BITS  = 60,
    parameter int IN_BYTES  = 4,
    parameter int NUM_OUT   = 4,
    parameter int CW        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [1:0]            nn_parameters,
    output logic                  fifo_w_ce,
    output logic                  fifo_beta_shift_ce,
    output logic                  fifo_minus_teta_ce,
    output logic                  fifo_BN_factor_ce,
    output logic                  fifo_BN_addend_ce,
    output logic [7:0]            inputs,
    output logic                  fifo_inputs_ce,
    output logic                  nn_ce,
    input  logic [NUM_OUT-1:0]    spikes,
    output logic [NUM_OUT*CW-1:0] spike_count,
    output logic                  result_valid,
    output logic                  done,
    output logic                  err,
    output logic                  busy
);

    // Dibit budgets per chain
    localparam logic [15:0] D_W    = 16'((W_BITS + 1) / 2);
    localparam logic [15:0] D_BETA = 16'((BETA_BITS + 1) / 2);
    localparam logic [15:0] D_TETA = 16'((TETA_BITS + 1) / 2);
    localparam logic [15:0] D_BNF  = 16'((BNF_BITS + 1) / 2);
    localparam logic [15:0] D_BNA  = 16'((BNA_BITS + 1) / 2);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_INP,
        S_RUNCNT,
        S_RUN,
        S_FIN
    } state_t;

    state_t      state_q;
    logic        init_q;      // holds in_ready low until the first clock after reset
    logic [2:0]  tgt_q;       // parameter chain being loaded
    logic [15:0] rem_q;       // dibits still owed to the chain after the one on the bus
    logic [1:0]  left_q;      // dibits of the current byte still to come after the one on the bus
    logic [5:0]  sh_q;        // undelivered dibits of the current byte
    logic [4:0]  pce_q;       // one-hot parameter strobes
    logic [1:0]  par_q;
    logic [7:0]  inp_q;
    logic        inp_ce_q;
    logic [7:0]  in_cnt_q;
    logic [7:0]  steps_q;     // nn_ce cycles remaining after the current one
    logic        nn_ce_q;
    logic        sample_q;    // previous cycle had nn_ce, so spikes are live now
    logic        done_q;
    logic        err_q;
    logic        rv_q;

    logic        rdy;
    logic        xfer;
    logic        cnt_clr;
    logic [15:0] hdr_budget;

    always_comb begin
        case (in_data[2:0])
            3'd0:    hdr_budget = D_W;
            3'd1:    hdr_budget = D_BETA;
            3'd2:    hdr_budget = D_TETA;
            3'd3:    hdr_budget = D_BNF;
            3'd4:    hdr_budget = D_BNA;
            default: hdr_budget = '0;
        endcase
    end

    // During a load a new byte is taken either when the bus is idle or in the
    // last dibit cycle of the current byte, which keeps the strobe gap-free.
    always_comb begin
        case (state_q)
            S_HDR, S_INP, S_RUNCNT: rdy = 1'b1;
            S_LOAD:  rdy = (pce_q == 5'd0) || ((left_q == 2'd0) && (rem_q != 16'd0));
            default: rdy = 1'b0;
        endcase
    end

    assign in_ready = init_q & rdy;
    assign xfer     = in_valid & in_ready;
    assign cnt_clr  = xfer && (state_q == S_RUNCNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HDR;
            init_q   <= 1'b0;
            tgt_q    <= 3'd0;
            rem_q    <= 16'd0;
            left_q   <= 2'd0;
            sh_q     <= 6'd0;
            pce_q    <= 5'd0;
            par_q    <= 2'd0;
            inp_q    <= 8'd0;
            inp_ce_q <= 1'b0;
            in_cnt_q <= 8'd0;
            steps_q  <= 8'd0;
            nn_ce_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            init_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            inp_ce_q <= 1'b0;
            inp_q    <= 8'd0;
            sample_q <= nn_ce_q;
            case (state_q)
                S_HDR: begin
                    if (xfer) begin
                        case (in_data[2:0])
                            3'd5: begin
                                in_cnt_q <= 8'd0;
                                state_q  <= S_INP;
                            end
                            3'd6: state_q <= S_RUNCNT;
                            3'd7: err_q <= 1'b1;
                            default: begin
                                tgt_q   <= in_data[2:0];
                                rem_q   <= hdr_budget;
                                state_q <= S_LOAD;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        pce_q  <= 5'b00001 << tgt_q;
                        par_q  <= in_data[1:0];
                        sh_q   <= in_data[7:2];
                        left_q <= 2'd3;
                        rem_q  <= rem_q - 16'd1;
                    end else if ((pce_q != 5'd0) && (rem_q == 16'd0)) begin
                        // Final dibit is on the bus; surplus dibits are dropped.
                        pce_q   <= 5'd0;
                        par_q   <= 2'd0;
                        done_q  <= 1'b1;
                        state_q <= S_HDR;
                    end else if ((pce_q != 5'd0) && (left_q != 2'd0)) begin
                        par_q  <= sh_q[1:0];
                        sh_q   <= {2'b00, sh_q[5:2]};
                        left_q <= left_q - 2'd1;
                        rem_q  <= rem_q - 16'd1;
                    end else begin
                        pce_q <= 5'd0;
                        par_q <= 2'd0;
                    end
                end
                S_INP: begin
                    if (xfer) begin
                        inp_q    <= in_data;
                        inp_ce_q <= 1'b1;
                        in_cnt_q <= in_cnt_q + 8'd1;
                        if (in_cnt_q == 8'(IN_BYTES - 1)) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_HDR;
                end
                S_RUNCNT: begin
                    if (xfer) begin
                        rv_q    <= 1'b0;
                        nn_ce_q <= (in_data != 8'd0);
                        steps_q <= in_data - 8'd1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (nn_ce_q) begin
                        if (steps_q != 8'd0) begin
                            steps_q <= steps_q - 8'd1;
                        end else begin
                            nn_ce_q <= 1'b0;
                        end
                    end else begin
                        // The last spike sample is taken this cycle.
                        done_q  <= 1'b1;
                        rv_q    <= 1'b1;
                        state_q <= S_HDR;
                    end
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_cnt
            logic [CW-1:0] cnt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (cnt_clr) begin
                    cnt_q <= '0;
                end else if (sample_q && spikes[gi] && (cnt_q != {CW{1'b1}})) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            assign spike_count[gi*CW +: CW] = cnt_q;
        end
    endgenerate

    assign nn_parameters      = par_q;
    assign fifo_w_ce          = pce_q[0];
    assign fifo_beta_shift_ce = pce_q[1];
    assign fifo_minus_teta_ce = pce_q[2];
    assign fifo_BN_factor_ce  = pce_q[3];
    assign fifo_BN_addend_ce  = pce_q[4];
    assign inputs             = inp_q;
    assign fifo_inputs_ce     = inp_ce_q;
    assign nn_ce              = nn_ce_q;
    assign result_valid       = rv_q;
    assign done               = done_q;
    assign err                = err_q;
    assign busy               = (state_q != S_HDR);

endmodule

// File: tb/tb_nn_param_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for nn_param_sequencer (CW=4 so saturation is reachable).
// Commands are issued through a handshaking driver; for each command the
// expected output events (kind, value, cycles since the last accepted byte)
// are queued from a command-level model. A monitor on the falling edge turns
// every DUT output event into the same form and compares it with the queue.
// ---------------------------------------------------------------------------
module tb_nn_param_sequencer;
    localparam int NUM_OUT = 4;
    localparam int CW      = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [7:0]            in_data = 8'd0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [1:0]            nn_parameters;
    logic                  fifo_w_ce, fifo_beta_shift_ce, fifo_minus_teta_ce;
    logic                  fifo_BN_factor_ce, fifo_BN_addend_ce;
    logic [7:0]            inputs;
    logic                  fifo_inputs_ce;
    logic                  nn_ce;
    logic [NUM_OUT-1:0]    spikes = '0;
    logic [NUM_OUT*CW-1:0] spike_count;
    logic                  result_valid, done, err, busy;

    nn_param_sequencer #(.CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .nn_parameters(nn_parameters),
        .fifo_w_ce(fifo_w_ce), .fifo_beta_shift_ce(fifo_beta_shift_ce),
        .fifo_minus_teta_ce(fifo_minus_teta_ce), .fifo_BN_factor_ce(fifo_BN_factor_ce),
        .fifo_BN_addend_ce(fifo_BN_addend_ce),
        .inputs(inputs), .fifo_inputs_ce(fifo_inputs_ce),
        .nn_ce(nn_ce), .spikes(spikes), .spike_count(spike_count),
        .result_valid(result_valid), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0..4 parameter dibit on chain k, 5 input byte, 6 nn_ce,
    // 7 done (data = {result_valid, spike_count}), 8 err.
    typedef struct {
        int kind;
        int data;
        int lat;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fixed_q[$];
    int         checks = 0;
    int         errors = 0;
    int         last_acc = 0;
    bit         mon_off = 1'b0;
    int         mdl_cnt[NUM_OUT];
    bit         mdl_rv = 1'b0;
    int         budget[5] = '{80, 5, 8, 24, 30};
    int         mon_ns;

    function automatic void push(input int k, input int d, input int l);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.lat  = l;
        exp_q.push_back(e);
    endfunction

    function automatic int cnt_word();
        int w;
        w = mdl_rv ? 32'h10000 : 0;
        for (int i = 0; i < NUM_OUT; i++) w = w | (mdl_cnt[i] << (i * CW));
        return w;
    endfunction

    function automatic void mdl_reset();
        for (int i = 0; i < NUM_OUT; i++) mdl_cnt[i] = 0;
        mdl_rv = 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic got(input int kind, input int data);
        ev_t e;
        int  lat;
        lat = cyc - last_acc;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got kind=%0d data=%0h lat=%0d expected none", kind, data, lat);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data || e.lat != lat) begin
                errors++;
                $display("FAIL event got kind=%0d data=%0h lat=%0d expected kind=%0d data=%0h lat=%0d",
                         kind, data, lat, e.kind, e.data, e.lat);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !mon_off) begin
            mon_ns = $countones({fifo_BN_addend_ce, fifo_BN_factor_ce, fifo_minus_teta_ce,
                                 fifo_beta_shift_ce, fifo_w_ce, fifo_inputs_ce});
            checks++;
            if (mon_ns > 1 || (mon_ns == 0 && nn_parameters != 2'd0)) begin
                errors++;
                $display("FAIL strobe_exclusive got strobes=%0d par=%0d expected at most one strobe",
                         mon_ns, nn_parameters);
            end
            if (fifo_w_ce)          got(0, int'(nn_parameters));
            if (fifo_beta_shift_ce) got(1, int'(nn_parameters));
            if (fifo_minus_teta_ce) got(2, int'(nn_parameters));
            if (fifo_BN_factor_ce)  got(3, int'(nn_parameters));
            if (fifo_BN_addend_ce)  got(4, int'(nn_parameters));
            if (fifo_inputs_ce)     got(5, int'(inputs));
            if (nn_ce)              got(6, 0);
            if (done)               got(7, int'({result_valid, spike_count}));
            if (err)                got(8, 0);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        for (int i = 0; i < gap; i++) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 4000) break;
        end
        checks++;
        if (t > 4000) begin
            errors++;
            $display("FAIL send_timeout got in_ready=0 expected acceptance of %02h", b);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            last_acc = cyc - 1;
            in_valid = 1'b0;
        end
    endtask

    function automatic logic [7:0] next_byte();
        if (fixed_q.size() > 0) return fixed_q.pop_front();
        return 8'($urandom);
    endfunction

    task automatic cmd_load(input logic [7:0] h, input int gmax);
        int         rem, m, tgt;
        logic [7:0] b;
        tgt = int'(h[2:0]);
        $display("cmd load hdr=%02h dibits=%0d", h, budget[tgt]);
        send(h, $urandom_range(0, gmax));
        rem = budget[tgt];
        while (rem > 0) begin
            b = next_byte();
            m = (rem > 4) ? 4 : rem;
            for (int j = 0; j < m; j++) push(tgt, int'((b >> (2 * j)) & 8'd3), j + 1);
            rem -= m;
            if (rem == 0) push(7, cnt_word(), m + 1);
            send(b, $urandom_range(0, gmax));
        end
    endtask

    task automatic cmd_inp(input logic [7:0] h, input int gmax);
        logic [7:0] b;
        $display("cmd inputs hdr=%02h", h);
        send(h, $urandom_range(0, gmax));
        for (int i = 0; i < 4; i++) begin
            b = next_byte();
            push(5, int'(b), 1);
            if (i == 3) push(7, cnt_word(), 2);
            send(b, $urandom_range(0, gmax));
        end
    endtask

    task automatic cmd_run(input logic [7:0] h, input int n, input logic [NUM_OUT-1:0] sp, input int gmax);
        $display("cmd run hdr=%02h steps=%0d spikes=%b", h, n, sp);
        send(h, $urandom_range(0, gmax));
        spikes = sp;
        for (int i = 0; i < NUM_OUT; i++) mdl_cnt[i] = sp[i] ? ((n > 15) ? 15 : n) : 0;
        mdl_rv = 1'b1;
        for (int j = 1; j <= n; j++) push(6, 0, j);
        push(7, cnt_word(), n + 2);
        send(8'(n), $urandom_range(0, gmax));
    endtask

    task automatic cmd_err(input int gmax);
        logic [7:0] h;
        h = 8'($urandom);
        h[2:0] = 3'd7;
        $display("cmd illegal hdr=%02h", h);
        push(8, 0, 1);
        send(h, $urandom_range(0, gmax));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int         sel;
        logic [7:0] h;
        mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_strobes", int'({fifo_w_ce, fifo_beta_shift_ce, fifo_minus_teta_ce,
                                  fifo_BN_factor_ce, fifo_BN_addend_ce, fifo_inputs_ce, nn_ce}), 0);
        chk("rst_pulses", int'({done, err, result_valid, busy}), 0);
        chk("rst_data", int'({nn_parameters, inputs, spike_count}), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_busy", int'(busy), 0);

        fixed_q.push_back(8'hE4);
        fixed_q.push_back(8'h03);
        cmd_load(8'h01, 0);
        cmd_load(8'h00, 0);
        fixed_q.push_back(8'h11);
        fixed_q.push_back(8'h22);
        fixed_q.push_back(8'h33);
        fixed_q.push_back(8'h44);
        cmd_inp(8'h05, 0);
        cmd_run(8'h06, 10, 4'b0101, 0);
        cmd_run(8'h06, 255, 4'hF, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("run_in_ready", int'(in_ready), 0);
        chk("run_busy", int'(busy), 1);
        cmd_run(8'h06, 0, 4'hA, 0);
        cmd_err(0);
        drain();

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 3);
            h = 8'($urandom);
            case (sel)
                0: begin
                    h[2:0] = 3'($urandom_range(0, 4));
                    cmd_load(h, 3);
                end
                1: begin
                    h[2:0] = 3'd5;
                    cmd_inp(h, 3);
                end
                2: begin
                    h[2:0] = 3'd6;
                    cmd_run(h, $urandom_range(0, 40), 4'($urandom), 3);
                end
                default: cmd_err(3);
            endcase
        end
        drain();

        // Reset in the middle of a weight load.
        mon_off = 1'b1;
        $display("cmd load hdr=00 interrupted by reset");
        send(8'h00, 0);
        for (int i = 0; i < 7; i++) send(8'($urandom), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_strobes", int'({fifo_w_ce, fifo_beta_shift_ce, fifo_minus_teta_ce,
                                     fifo_BN_factor_ce, fifo_BN_addend_ce, fifo_inputs_ce, nn_ce}), 0);
        chk("midrst_par", int'(nn_parameters), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_counts", int'({result_valid, spike_count}), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl_reset();
        mon_off = 1'b0;
        @(posedge clk);
        #1;
        cmd_load(8'h02, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
